falcon_sample_assembler: RTL and testbench
==========================================

// Module: falcon_sample_assembler
// PURPOSE
//  Consumer end of the sampler_sw centre-split interface. Queues integer centres (s_int) from
//  sampler_sw and drives trials into the rejection loop (base sampler + BerExp) for the head
//  centre. On an accepted trial it forms the final FALCON sample s_int + z and presents it on a
//  valid/ready output port. Sits between sampler_sw and the ffSampling result collector.
// PARAMETERS
//  DEPTH      4   centre FIFO entries; power of two, >=2
//  ZW         8   width of signed trial offset try_z
//  MAX_TRIES  16  rejected trials before abort (used only with SAMPLER_TRY_LIMIT_EN)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  ctr_valid    in   1   centre valid (driven by sampler_sw valid_out)
//  ctr_s_int    in   32  signed integer centre floor(mu) (driven by sampler_sw s_int)
//  ctr_ready    out  1   FIFO can accept a centre
//  try_req      out  1   request one rejection trial for the head centre
//  try_valid    in   1   trial result valid; honoured only while try_req=1
//  try_accept   in   1   1 = trial accepted, 0 = rejected
//  try_z        in   ZW  signed offset z of the trial
//  out_valid    out  1   sample valid
//  out_ready    in   1   downstream accepts sample
//  out_sample   out  32  signed sample s_int + z
//  out_tries    out  8   trials used for this sample, including the accepted one
//  out_err      out  1   sample aborted at the try limit
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty, FSM=IDLE, try counter=0. try_req, out_valid, out_sample,
//   out_tries and out_err all 0. ctr_ready=1.
//  Push: centre written when ctr_valid & ctr_ready. ctr_ready = !full, independent of pop in the
//   same cycle, so there is no pass-through when full. Pointers wrap modulo DEPTH.
//  FSM IDLE: FIFO empty. The first push at edge N gives FSM=REQ and try_req=1 from cycle N+1.
//  FSM REQ: try_req held 1. At an edge with try_valid=1:
//   accept -> out_sample <= head + sign_ext(try_z) (two's-complement wrap mod 2^32);
//     out_tries <= cnt+1; out_err=0; pop head; FSM=OUT; try_req=0 from next cycle.
//   reject -> cnt <= cnt+1 (saturates at 255); stay in REQ with try_req held 1.
//   try_valid while try_req=0 is ignored.
//  FSM OUT: out_valid=1; out_sample, out_tries and out_err are stable until out_valid&out_ready.
//   On the handshake edge: cnt <= 0. If the FIFO is non-empty (after any same-edge push), next
//   state is REQ, otherwise IDLE. out_valid falls in the next cycle.
//  Pushes are accepted in every state. Throughput is at most 1 sample per 2 cycles.
//   A push in the same cycle as a pop is legal; the count is unchanged.
//  Latency: accept edge N -> out_valid at N+1. Empty-FIFO push -> try_req at N+1.
//  Reset mid-operation: queued centres and any in-flight trial are discarded.
//   try_req and out_valid drop immediately (async).
// CONFIGURATION
//  SAMPLER_TRY_LIMIT_EN defined: in REQ, if a reject makes cnt reach MAX_TRIES, the FSM moves to OUT
//   with out_sample=head (z=0), out_tries=MAX_TRIES and out_err=1, and pops the head.
//  SAMPLER_TRY_LIMIT_EN undefined: trials retry indefinitely; out_err is tied to 0 and
//   MAX_TRIES is unused.
// TESTING
//  1 push s_int=-22; reject, then accept z=+1 -> out_sample=-21, out_tries=2, out_err=0.
//  2 push s_int=10; 2 rejects, then accept z=-1 (8'hFF) -> out_sample=9, out_tries=3.
//  3 hold try_valid=0 and push 5 centres 1..5 (DEPTH=4) -> ctr_ready=0 after the 4th;
//    accept z=0 x4 -> samples 1,2,3,4 in order, then 5 is queued on the freed slot.
//  4 out_ready=0 for 5 cycles after an accept -> out_valid stays 1, payload constant, try_req=0;
//    after the handshake, try_req=1 on the next cycle if the FIFO is non-empty.
//  5 drop rst_n while in REQ with 3 centres queued -> try_req=0 immediately; ctr_ready=1;
//    after release, no trial requests until a new push.
//  6 SAMPLER_TRY_LIMIT_EN on, MAX_TRIES=16, s_int=7, 16 rejects -> out_sample=7, out_tries=16,
//    out_err=1. With the macro off, the same stimulus keeps try_req=1 and out_valid=0.

Source files
------------

// File: rtl/falcon_sample_assembler.sv
// Queues integer centres from sampler_sw and runs rejection trials on the head centre.
// On acceptance it emits s_int + z. Define SAMPLER_TRY_LIMIT_EN to abort after MAX_TRIES rejects.
module falcon_sample_assembler #(
  parameter int DEPTH     = 4,
  parameter int ZW        = 8,
  parameter int MAX_TRIES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ctr_valid,
  input  logic [31:0]   ctr_s_int,
  output logic          ctr_ready,
  output logic          try_req,
  input  logic          try_valid,
  input  logic          try_accept,
  input  logic [ZW-1:0] try_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_sample,
  output logic [7:0]    out_tries,
  output logic          out_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;

  state_t        state_reg;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [7:0]    cnt_reg;

  logic        push;
  logic        pop;
  logic        limit_hit;
  logic [31:0] head;
  logic [31:0] z_ext;
  logic [7:0]  cnt_inc;

  assign ctr_ready = (count_reg != (AW+1)'(DEPTH));
  assign push      = ctr_valid & ctr_ready;
  assign head      = mem[rd_ptr_reg];
  assign z_ext     = {{(32-ZW){try_z[ZW-1]}}, try_z};
  assign cnt_inc   = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;

`ifdef SAMPLER_TRY_LIMIT_EN
  assign limit_hit = !try_accept && (cnt_inc == 8'(MAX_TRIES));
`else
  // Without the limit, trials retry forever and out_err never rises.
  logic unused_max_tries;
  assign unused_max_tries = ^MAX_TRIES;
  assign limit_hit        = 1'b0;
`endif

  assign pop = (state_reg == REQ) && try_valid && (try_accept || limit_hit);

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= ctr_s_int;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      cnt_reg    <= '0;
      try_req    <= 1'b0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_tries  <= '0;
      out_err    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);

      case (state_reg)
        IDLE: begin
          if (push || count_reg != '0) begin
            state_reg <= REQ;
            try_req   <= 1'b1;
          end
        end
        REQ: begin
          if (try_valid) begin
            if (try_accept) begin
              out_sample <= head + z_ext;
              out_tries  <= cnt_inc;
              out_err    <= 1'b0;
              out_valid  <= 1'b1;
              try_req    <= 1'b0;
              state_reg  <= OUT;
            end else if (limit_hit) begin
              out_sample <= head;
              out_tries  <= 8'(MAX_TRIES);
              out_err    <= 1'b1;
              out_valid  <= 1'b1;
              try_req    <= 1'b0;
              state_reg  <= OUT;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            cnt_reg   <= '0;
            out_valid <= 1'b0;
            // No pop happens in OUT, so occupancy after this edge is count + push.
            if (count_reg != '0 || push) begin
              state_reg <= REQ;
              try_req   <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          try_req   <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_falcon_sample_assembler.sv
// Self-checking bench for falcon_sample_assembler: vector table, corner sequences, random model run.
module tb_falcon_sample_assembler;

  logic        clk;
  logic        rst_n;
  logic        ctr_valid;
  logic [31:0] ctr_s_int;
  logic        ctr_ready;
  logic        try_req;
  logic        try_valid;
  logic        try_accept;
  logic [7:0]  try_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sample;
  logic [7:0]  out_tries;
  logic        out_err;

  int errors = 0;
  int checks = 0;

  falcon_sample_assembler #(.DEPTH(4), .ZW(8), .MAX_TRIES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctr_valid  (ctr_valid),
    .ctr_s_int  (ctr_s_int),
    .ctr_ready  (ctr_ready),
    .try_req    (try_req),
    .try_valid  (try_valid),
    .try_accept (try_accept),
    .try_z      (try_z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_tries  (out_tries),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] s_int;
    int          nrej;
    logic [7:0]  z;
    logic [31:0] exp_sample;
    logic [7:0]  exp_tries;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [31:0] v);
    int n = 0;
    while (!ctr_ready && n < 20) begin
      step();
      n++;
    end
    chk("push_ready", ctr_ready, 1);
    ctr_valid = 1'b1;
    ctr_s_int = v;
    step();
    ctr_valid = 1'b0;
  endtask

  task automatic trial(input logic acc, input logic [7:0] z);
    int n = 0;
    while (!try_req && n < 20) begin
      step();
      n++;
    end
    chk("try_req_wait", try_req, 1);
    try_valid  = 1'b1;
    try_accept = acc;
    try_z      = z;
    step();
    try_valid  = 1'b0;
    try_accept = 1'b0;
  endtask

  task automatic take(input logic [31:0] es, input logic [7:0] et, input logic ee, input string tag);
    chk({tag, "_valid"},  out_valid, 1);
    chk({tag, "_sample"}, out_sample, es);
    chk({tag, "_tries"},  out_tries, et);
    chk({tag, "_err"},    out_err, ee);
    $display("sample %s: value=%0d tries=%0d err=%0d", tag, $signed(out_sample), out_tries, out_err);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_fall"}, out_valid, 0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] hold;
    logic [31:0] head;
    logic [7:0]  z;
    int          k;
    int          npush;
    int          d;

    vecs[0] = '{32'hFFFF_FFEA, 1, 8'h01, 32'hFFFF_FFEB, 8'd2};  // -22 + 1 = -21
    vecs[1] = '{32'd10,        2, 8'hFF, 32'd9,         8'd3};  // 10 - 1 = 9
    vecs[2] = '{32'h7FFF_FFFF, 0, 8'h01, 32'h8000_0000, 8'd1};  // wraps mod 2^32
    vecs[3] = '{32'd0,         3, 8'h80, 32'hFFFF_FF80, 8'd4};  // most negative z

    rst_n = 1'b0; ctr_valid = 1'b0; ctr_s_int = '0;
    try_valid = 1'b0; try_accept = 1'b0; try_z = '0; out_ready = 1'b0;
    #1;
    chk("rst_try_req", try_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_out_tries", out_tries, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_ctr_ready", ctr_ready, 1);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle_no_req", try_req, 0);

    // Table vectors
    for (int i = 0; i < 4; i++) begin
      do_push(vecs[i].s_int);
      chk($sformatf("vec%0d_req_latency", i), try_req, 1);
      for (int r = 0; r < vecs[i].nrej; r++) trial(1'b0, 8'h00);
      trial(1'b1, vecs[i].z);
      take(vecs[i].exp_sample, vecs[i].exp_tries, 1'b0, $sformatf("vec%0d", i));
    end

    // FIFO fill and order
    for (int v = 1; v <= 4; v++) do_push(32'(v));
    chk("full_ready_low", ctr_ready, 0);
    trial(1'b1, 8'h00);
    chk("freed_ready_high", ctr_ready, 1);
    do_push(32'd5);
    take(32'd1, 8'd1, 1'b0, "fifo1");
    for (int v = 2; v <= 5; v++) begin
      trial(1'b1, 8'h00);
      take(32'(v), 8'd1, 1'b0, $sformatf("fifo%0d", v));
    end

    // Backpressure holds the payload
    do_push(32'd100);
    do_push(32'd200);
    trial(1'b1, 8'd5);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_sample", out_sample, 32'd105);
      chk("bp_tries", out_tries, 1);
      chk("bp_no_req", try_req, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_valid_fall", out_valid, 0);
    chk("bp_req_next", try_req, 1);
    trial(1'b1, 8'h00);
    take(32'd200, 8'd1, 1'b0, "bp_second");

    // Asynchronous reset with centres queued
    do_push(32'd11);
    do_push(32'd12);
    do_push(32'd13);
    chk("pre_rst_req", try_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", try_req, 0);
    chk("async_rst_ready", ctr_ready, 1);
    chk("async_rst_valid", out_valid, 0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst_no_req", try_req, 0);
    end
    do_push(32'd44);
    chk("post_rst_req", try_req, 1);
    trial(1'b1, 8'h00);
    take(32'd44, 8'd1, 1'b0, "post_rst");

    // Try limit
    do_push(32'd7);
    for (int r = 0; r < 16; r++) trial(1'b0, 8'h00);
`ifdef SAMPLER_TRY_LIMIT_EN
    take(32'd7, 8'd16, 1'b1, "limit");
`else
    chk("nolimit_req", try_req, 1);
    chk("nolimit_valid", out_valid, 0);
    trial(1'b1, 8'h00);
    take(32'd7, 8'd17, 1'b0, "nolimit");
`endif

    // Randomised run against a queue model
    for (int it = 0; it < 40; it++) begin
      npush = $urandom_range((q.size() == 0) ? 1 : 0, (4 - q.size() > 2) ? 2 : 4 - q.size());
      for (int p = 0; p < npush; p++) begin
        hold = $urandom;
        chk("rnd_ready", ctr_ready, (q.size() < 4) ? 1 : 0);
        do_push(hold);
        q.push_back(hold);
      end
      k = $urandom_range(0, 3);
      for (int r = 0; r < k; r++) trial(1'b0, 8'($urandom));
      z = 8'($urandom);
      trial(1'b1, z);
      head = q.pop_front();
      hold = 32'(int'($signed(head)) + int'($signed(z)));
      d = $urandom_range(0, 2);
      for (int c = 0; c < d; c++) begin
        chk("rnd_hold", out_sample, hold);
        step();
      end
      take(hold, 8'(k + 1), 1'b0, $sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
